// File: rtl/cipher_sequencer.sv
// Command sequencer for a byte cipher: key loading, encrypt launch with a
// BUSY watchdog, and hand-off of held results to the output mux.
module cipher_sequencer #(
  parameter int KEY_BYTES = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       key_wr_en,
  output logic [3:0] key_wr_idx,
  output logic [7:0] key_byte,
  output logic       cipher_start,
  output logic [7:0] cipher_byte,
  input  logic       output_is_ready,
  output logic       holder_release,
  output logic       out_sel,
  output logic [2:0] state_out,
  output logic       err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_READY    = 3'd2,
    ST_BUSY     = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  localparam logic [1:0] CMD_LOAD    = 2'b00;
  localparam logic [1:0] CMD_ENCRYPT = 2'b01;
  localparam logic [1:0] CMD_ACK     = 2'b10;
  localparam logic [1:0] CMD_ABORT   = 2'b11;
  localparam logic [3:0] LAST_IDX    = 4'(KEY_BYTES - 1);
  localparam logic [7:0] LAST_CNT    = 8'(TIMEOUT - 1);

  state_e      state_r;
  logic        key_valid_r;
  logic [3:0]  key_idx_r;
  logic [7:0]  cnt_r;
  logic        accept_s;
  logic        abort_s;
  logic        key_last_s;

  // ABORT bypasses cmd_ready so it can cancel an encryption in flight.
  assign accept_s   = cmd_valid && (cmd_ready || (cmd == CMD_ABORT));
  assign abort_s    = accept_s && (cmd == CMD_ABORT);
  assign key_last_s = (key_idx_r == LAST_IDX);
  assign cmd_ready  = (state_r != ST_BUSY);
  assign out_sel    = (state_r == ST_HOLD);
  assign state_out  = state_r;

  // Main sequencer: state, key index, watchdog counter and registered strobes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r        <= ST_IDLE;
      key_valid_r    <= 1'b0;
      key_idx_r      <= 4'd0;
      cnt_r          <= 8'd0;
      err            <= 1'b0;
      key_wr_en      <= 1'b0;
      key_wr_idx     <= 4'd0;
      key_byte       <= 8'd0;
      cipher_start   <= 1'b0;
      cipher_byte    <= 8'd0;
      holder_release <= 1'b0;
    end else begin
      key_wr_en      <= 1'b0;
      cipher_start   <= 1'b0;
      holder_release <= 1'b0;
      if (abort_s) begin
        state_r   <= key_valid_r ? ST_READY : ST_IDLE;
        err       <= 1'b0;
        key_idx_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE, ST_LOAD_KEY, ST_READY: begin
            if (accept_s) begin
              if (cmd == CMD_LOAD) begin
                // key_idx_r is 0 outside LOAD_KEY, so IDLE/READY write index 0
                key_wr_en  <= 1'b1;
                key_wr_idx <= key_idx_r;
                key_byte   <= cmd_data;
                if (key_last_s) begin
                  state_r     <= ST_READY;
                  key_valid_r <= 1'b1;
                  key_idx_r   <= 4'd0;
                end else begin
                  state_r     <= ST_LOAD_KEY;
                  key_valid_r <= 1'b0;
                  key_idx_r   <= key_idx_r + 4'd1;
                end
              end else if ((cmd == CMD_ENCRYPT) && (state_r == ST_READY)) begin
                cipher_start <= 1'b1;
                cipher_byte  <= cmd_data;
                cnt_r        <= 8'd0;
                state_r      <= ST_BUSY;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ST_BUSY: begin
            // A result arriving on the timeout cycle still wins.
            if (output_is_ready) begin
              state_r <= ST_HOLD;
            end else if (cnt_r == LAST_CNT) begin
              err     <= 1'b1;
              state_r <= ST_READY;
            end else begin
              cnt_r <= cnt_r + 8'd1;
            end
          end
          ST_HOLD: begin
            if (accept_s) begin
              if (cmd == CMD_ACK) begin
                holder_release <= 1'b1;
                state_r        <= ST_READY;
              end else begin
                err <= 1'b1;
              end
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/cipher_sequencer.md
CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 Parameter KEY_BYTES, default 4, SHALL set the number of key bytes per key load (legal range 1..16).
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent in BUSY before abort (legal range 2..255).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 nrst  in  1  reset; asynchronous, active-low.
REQ-005 cmd_valid  in  1  user command strobe; a command is accepted when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-006 cmd  in  2  command code: 00 LOAD_KEY, 01 ENCRYPT, 10 READ_ACK, 11 ABORT.
REQ-007 cmd_data  in  8  operand byte for LOAD_KEY and ENCRYPT.
REQ-008 cmd_ready  out  1  command acceptance.
REQ-009 key_wr_en  out  1  one-cycle key-register write strobe.
REQ-010 key_wr_idx  out  4  key byte index for key_wr_en.
REQ-011 key_byte  out  8  key byte for key_wr_en.
REQ-012 cipher_start  out  1  one-cycle start pulse to the encryption block.
REQ-013 cipher_byte  out  8  plaintext byte, valid with cipher_start.
REQ-014 output_is_ready  in  1  from the output holder: held result available.
REQ-015 holder_release  out  1  one-cycle pulse telling the output holder the result was read.
REQ-016 out_sel  out  1  output mux select: 0 status, 1 held cipher data.
REQ-017 state_out  out  3  current state encoding (IDLE 0, LOAD_KEY 1, READY 2, BUSY 3, HOLD 4).
REQ-018 err  out  1  sticky error flag.

Function
REQ-019 cmd_ready SHALL be 1 in IDLE, LOAD_KEY, READY and HOLD, and 0 in BUSY.
REQ-020 ABORT with cmd_valid=1 SHALL be accepted in every state, including BUSY.
REQ-021 ABORT SHALL go to READY if a complete key is loaded, else to IDLE, clear err, and clear the key index.
REQ-022 IDLE: LOAD_KEY SHALL write index 0 and go to LOAD_KEY (or to READY if KEY_BYTES=1); ENCRYPT or READ_ACK SHALL set err and stay.
REQ-023 LOAD_KEY: each LOAD_KEY SHALL write the next index; the write at index KEY_BYTES-1 SHALL go to READY, set key_valid, and reset the index to 0.
REQ-024 LOAD_KEY: ENCRYPT or READ_ACK SHALL set err and leave state and index unchanged.
REQ-025 Key writes SHALL drive key_wr_en=1 with key_wr_idx and key_byte=cmd_data in the cycle after acceptance (registered, latency 1).
REQ-026 READY: ENCRYPT SHALL assert cipher_start with cipher_byte=cmd_data in the next cycle, go to BUSY, and load the timeout counter with 0.
REQ-027 READY: LOAD_KEY SHALL clear key_valid, write index 0, and go to LOAD_KEY (rekey); READ_ACK SHALL set err.
REQ-028 BUSY: the counter SHALL increment each cycle; output_is_ready=1 SHALL go to HOLD; when the counter reaches TIMEOUT-1 without output_is_ready, SHALL set err and go to READY.
REQ-029 If output_is_ready and the timeout coincide in the same cycle, SHALL go to HOLD with no error.
REQ-030 HOLD: out_sel SHALL be 1; READ_ACK SHALL pulse holder_release for exactly one cycle (next cycle) and go to READY.
REQ-031 HOLD: LOAD_KEY or ENCRYPT SHALL set err and stay in HOLD.
REQ-032 out_sel SHALL be 0 in every state other than HOLD.
REQ-033 key_wr_en, cipher_start and holder_release SHALL each be high for at most one cycle per accepted command, and SHALL never be high together.
REQ-034 err SHALL remain set until ABORT or reset.

Reset
REQ-035 nrst=0 SHALL immediately force state IDLE, key_valid 0, key index 0, counter 0, err 0, and all outputs to 0, except cmd_ready=1.
REQ-036 Reset asserted mid-operation (any state) SHALL discard any pending pulse; no strobe SHALL appear in the cycle after release.

Verification
REQ-037 Reset, then 4x LOAD_KEY with 0xA0..0xA3 -> key_wr_idx 0..3 with matching key_byte, one cycle after each; state_out=2 after the 4th.
REQ-038 READY, ENCRYPT 0x5A -> cipher_start for 1 cycle with cipher_byte=0x5A; output_is_ready 3 cycles later -> state_out=4, out_sel=1; READ_ACK -> holder_release for 1 cycle, state_out=2.
REQ-039 BUSY with output_is_ready held at 0 -> exactly TIMEOUT cycles later err=1 and state_out=2; output_is_ready on the final cycle -> HOLD, err=0.
REQ-040 ENCRYPT in IDLE, and READ_ACK in LOAD_KEY after 2 bytes -> err=1, state unchanged, next LOAD_KEY writes index 2.
REQ-041 ABORT during BUSY -> cmd accepted though cmd_ready=0, state_out=2, err cleared; nrst pulsed in HOLD -> state_out=0, out_sel=0, no holder_release.
